operand_sel_pipe: RTL and testbench

OPERAND_SEL_PIPE -- requirements
Module: operand_sel_pipe

---
 rtl/opsel_pkg.sv | 25 ++
 rtl/opsel_stage.sv | 35 +++
 rtl/operand_sel_pipe.sv | 108 ++++++++++
 tb/tb_operand_sel_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/opsel_pkg.sv
// Shared definitions for the operand select pipeline: width helper,
// mode encoding and legal parameter ranges.
package opsel_pkg;

  localparam int N_MIN      = 2;
  localparam int N_MAX      = 16;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_AUTO   = 1'b1
  } opsel_mode_e;

  // Smallest r with 2**r >= v (at least 1 bit for v >= 2).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/opsel_stage.sv
// One pipeline register slice holding {valid, data, chan}.
module opsel_stage #(
  parameter int W     = 32,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,     // active-high despite the name
  input  logic             flush,
  input  logic             load,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic [SEL_W-1:0] in_chan,
  output logic             valid,
  output logic [W-1:0]     data,
  output logic [SEL_W-1:0] chan
);

  // Capture upstream contents when this slice is empty or draining; flush only drops valid.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      chan  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
        chan <= in_chan;
      end
    end
  end

endmodule

// File: rtl/operand_sel_pipe.sv
// Selects one of N input channels (direct or round-robin) and carries the
// word plus its channel index through a STAGES-deep ready/valid pipeline.
module operand_sel_pipe
  import opsel_pkg::*;
#(
  parameter int  W      = 32,
  parameter int  N      = 4,
  parameter int  STAGES = 2,
  localparam int SEL_W  = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,     // active-high asynchronous reset
  input  logic [N*W-1:0]   in_data,
  input  logic [SEL_W-1:0] sel,
  input  logic             mode,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  if (N < N_MIN || N > N_MAX || STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_param
    $error("operand_sel_pipe: N or STAGES outside legal range");
  end

  logic [STAGES-1:0] st_v;
  logic [STAGES-1:0] st_ld;
  logic [W-1:0]      st_d [STAGES];
  logic [SEL_W-1:0]  st_c [STAGES];

  logic [SEL_W-1:0]  ctr;
  logic [SEL_W-1:0]  mux_chan;
  logic [W-1:0]      mux_data;
  logic              accept;

  // Channel choice: counter in auto mode, clamped sel in direct mode.
  always_comb begin
    mux_chan = ctr;
    if (mode == MODE_DIRECT) begin
      if (int'(sel) >= N) mux_chan = SEL_W'(N - 1);
      else                mux_chan = sel;
    end
    mux_data = in_data[int'(mux_chan)*W +: W];
  end

  // Load enables ripple back from the output: a full stage may reload only if its successor takes its beat.
  always_comb begin
    st_ld = '0;
    st_ld[STAGES-1] = !st_v[STAGES-1] || out_ready;
    for (int unsigned i = 1; i < STAGES; i++) begin
      st_ld[STAGES-1-i] = !st_v[STAGES-1-i] || st_ld[STAGES-i];
    end
  end

  assign in_ready = st_ld[0] && !flush;
  assign accept   = in_valid && in_ready;

  // Round-robin counter: advances per auto-mode accept, cleared by flush.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ctr <= '0;
    end else if (flush) begin
      ctr <= '0;
    end else if (accept && mode == MODE_AUTO) begin
      ctr <= (ctr == SEL_W'(N - 1)) ? '0 : ctr + 1'b1;
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic             in_v;
    logic [W-1:0]     in_d;
    logic [SEL_W-1:0] in_c;

    if (g == 0) begin : g_head
      assign in_v = accept;
      assign in_d = mux_data;
      assign in_c = mux_chan;
    end else begin : g_body
      assign in_v = st_v[g-1];
      assign in_d = st_d[g-1];
      assign in_c = st_c[g-1];
    end

    opsel_stage #(
      .W     (W),
      .SEL_W (SEL_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .load     (st_ld[g]),
      .in_valid (in_v),
      .in_data  (in_d),
      .in_chan  (in_c),
      .valid    (st_v[g]),
      .data     (st_d[g]),
      .chan     (st_c[g])
    );
  end

  assign out_valid = st_v[STAGES-1];
  assign out_data  = st_d[STAGES-1];
  assign out_chan  = st_c[STAGES-1];

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Directed bench for operand_sel_pipe: main build (W=32,N=4,STAGES=2) plus
// an N=6 build and a STAGES=1 build for the width/latency edge cases.
module tb_operand_sel_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush;

  // main build
  logic [127:0] in_data;
  logic [1:0]   sel, out_chan;
  logic         mode, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]  out_data;

  // N=6 build
  logic [47:0]  in_data6;
  logic [2:0]   sel6, out_chan6;
  logic         mode6, in_valid6, in_ready6, out_valid6, out_ready6;
  logic [7:0]   out_data6;

  // STAGES=1 build
  logic [63:0]  in_data1;
  logic [1:0]   sel1, out_chan1;
  logic         mode1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [15:0]  out_data1;

  int checks = 0;
  int errors = 0;

  operand_sel_pipe #(.W(32), .N(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .mode(mode),
    .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  operand_sel_pipe #(.W(8), .N(6), .STAGES(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data6), .sel(sel6), .mode(mode6),
    .flush(flush), .in_valid(in_valid6), .in_ready(in_ready6),
    .out_data(out_data6), .out_chan(out_chan6), .out_valid(out_valid6),
    .out_ready(out_ready6)
  );

  operand_sel_pipe #(.W(16), .N(4), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .sel(sel1), .mode(mode1),
    .flush(flush), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_chan(out_chan1), .out_valid(out_valid1),
    .out_ready(out_ready1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Main-build channel k carries 0x11*(k+1).
  function automatic logic [31:0] chv(input int unsigned k);
    return 32'h11 * (k + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned exp_q[$];
    int          sent;
    int          got;
    logic        prev_stall;

    rst_n      = 1'b1;
    flush      = 1'b0;
    in_data    = {32'h44, 32'h33, 32'h22, 32'h11};
    sel        = 2'd0;
    mode       = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    in_data6   = {8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
    sel6       = 3'd0;
    mode6      = 1'b0;
    in_valid6  = 1'b0;
    out_ready6 = 1'b1;
    in_data1   = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    sel1       = 2'd0;
    mode1      = 1'b0;
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;

    // reset state
    @(negedge clk);
    check("reset_valid", 64'(out_valid), 64'h0);
    check("reset_data",  64'(out_data),  64'h0);
    check("reset_chan",  64'(out_chan),  64'h0);
    rst_n = 1'b0;
    #1;
    check("ready_after_reset", 64'(in_ready), 64'h1);

    // direct select, two-cycle latency
    sel = 2'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("direct_lat1_valid", 64'(out_valid), 64'h0);
    step();
    check("direct_valid", 64'(out_valid), 64'h1);
    check("direct_data",  64'(out_data),  64'h33);
    check("direct_chan",  64'(out_chan),  64'h2);
    step();
    check("direct_drain", 64'(out_valid), 64'h0);

    // auto mode, six back-to-back accepts -> chans 0,1,2,3,0,1
    mode = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = (k < 6);
      step();
      if (k >= 1) begin
        check("auto_valid", 64'(out_valid), 64'h1);
        check("auto_chan",  64'(out_chan),  64'((k - 1) % 4));
        check("auto_data",  64'(out_data),  64'(chv((k - 1) % 4)));
      end
    end

    // flush with ctr=2 and a beat offered: beat dropped, ctr back to 0
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(in_ready), 64'h0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'h0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("post_flush_valid", 64'(out_valid), 64'h1);
    check("post_flush_chan",  64'(out_chan),  64'h0);
    check("post_flush_data",  64'(out_data),  64'h11);

    // ctr (now 1) holds through a direct-mode accept and resumes in auto mode
    mode = 1'b0;
    sel = 2'd3;
    in_valid = 1'b1;
    step();
    mode = 1'b1;
    step();
    in_valid = 1'b0;
    check("mode_direct_chan", 64'(out_chan), 64'h3);
    check("mode_direct_data", 64'(out_data), 64'h44);
    step();
    check("mode_resume_chan", 64'(out_chan), 64'h1);
    check("mode_resume_data", 64'(out_data), 64'h22);
    step();
    mode = 1'b0;

    // 8-beat stream with a 3-cycle downstream stall
    sent = 0;
    got = 0;
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      if (prev_stall) check("stall_hold_valid", 64'(out_valid), 64'h1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_beat", 64'(out_valid), 64'h0);
        end else begin
          check("stream_chan", 64'(out_chan), 64'(exp_q[0]));
          check("stream_data", 64'(out_data), 64'(chv(exp_q[0])));
        end
      end
      in_valid  = (sent < 8);
      sel       = 2'(sent % 4);
      out_ready = !(cyc >= 4 && cyc < 7);
      #1;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(32'(sent % 4));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 64'(got), 64'd8);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);
    step();
    check("stream_idle", 64'(out_valid), 64'h0);

    // N=6: sel=5 selects channel 5; sel=7 clamps to channel 5
    check("n6_ready", 64'(in_ready6), 64'h1);
    sel6 = 3'd5;
    in_valid6 = 1'b1;
    step();
    sel6 = 3'd7;
    step();
    in_valid6 = 1'b0;
    check("n6_sel5_chan", 64'(out_chan6), 64'h5);
    check("n6_sel5_data", 64'(out_data6), 64'hA5);
    step();
    check("n6_clamp_valid", 64'(out_valid6), 64'h1);
    check("n6_clamp_chan",  64'(out_chan6),  64'h5);
    check("n6_clamp_data",  64'(out_data6),  64'hA5);

    // STAGES=1: top channel, latency of one cycle
    sel1 = 2'd3;
    in_valid1 = 1'b1;
    #1;
    check("s1_ready", 64'(in_ready1), 64'h1);
    check("s1_pre_valid", 64'(out_valid1), 64'h0);
    step();
    in_valid1 = 1'b0;
    check("s1_valid", 64'(out_valid1), 64'h1);
    check("s1_chan",  64'(out_chan1),  64'h3);
    check("s1_data",  64'(out_data1),  64'h1003);

    // asynchronous reset with two beats in flight
    sel = 2'd1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    check("rst_preload_valid", 64'(out_valid), 64'h1);
    check("rst_preload_data",  64'(out_data),  64'h22);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'h0);
    check("rst_async_data",  64'(out_data),  64'h0);
    check("rst_async_chan",  64'(out_chan),  64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_release_ready", 64'(in_ready), 64'h1);
    step();
    check("rst_discarded", 64'(out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
